conv1d_accel: RTL and testbench
===============================

// Module: conv1d_accel
// PURPOSE
//   Memory-mapped 1-D "valid" convolution accelerator for the user domain.
//   Host fills input and kernel buffers over an OBI subordinate port and
//   configures/starts it through a register-interface control block.
//   Results land in an output buffer readable over OBI; done raises done_int_o.
// PARAMETERS
//   N_MAX   64  max input samples (input/output buffer depth, words)
//   K_MAX   8   max kernel taps (kernel buffer depth, words)
// PORTS
//   clk_i         in   1   clock, all logic rising-edge
//   rst_i         in   1   synchronous reset, active-high
//   obi_req_i     in   1   OBI request
//   obi_we_i      in   1   1=write
//   obi_be_i      in   4   byte enables (writes)
//   obi_addr_i    in   32  byte address, only [9:2] decoded
//   obi_wdata_i   in   32  write data
//   obi_gnt_o     out  1   grant, always =obi_req_i (combinational)
//   obi_rvalid_o  out  1   response valid, 1 cycle after grant
//   obi_rdata_o   out  32  read data (0 for writes/unmapped)
//   obi_err_o     out  1   always 0
//   reg_valid_i   in   1   register access valid
//   reg_write_i   in   1   1=write
//   reg_addr_i    in   5   byte offset, [4:2] decoded
//   reg_wdata_i   in   32  write data
//   reg_wstrb_i   in   4   write strobes
//   reg_rdata_o   out  32  read data, combinational
//   reg_ready_o   out  1   always 1
//   reg_error_o   out  1   1 for unmapped offset
//   done_int_o    out  1   level interrupt = STATUS.done & IRQ_EN
// BEHAVIOUR
//   OBI map: 0x000-0x0FC input x[0..63]; 0x100-0x11C kernel w[0..7];
//     0x200-0x2FC output y[0..63]; all else reads 0, writes dropped.
//   Output buffer is read-only over OBI. While busy, OBI writes to input/kernel
//     are dropped (still granted/acknowledged); reads always served.
//   Registers: 0x00 CTRL bit0 START (write-1, self-clearing, reads 0);
//     0x04 STATUS bit0 busy(RO), bit1 done(W1C), bit2 cfg_err(W1C);
//     0x08 LEN [6:0] (N); 0x0C KLEN [3:0] (K); 0x10 IRQ_EN bit0. All reset 0.
//   Data: 32-bit signed; y[i] = sum_{k<K} x[i+k]*w[k], i=0..N-K; product and
//     accumulation truncated mod 2^32 (wrap, no saturation).
//   FSM: IDLE -> (START & cfg ok) RUN; RUN: one MAC/cycle, acc cleared at k=0,
//     K cycles per output; WRITE: store acc to y[i] (1 cycle), i++;
//     after i=N-K -> DONE (1 cycle, sets done, clears busy) -> IDLE.
//   Latency: busy=1 the cycle after START write; total (N-K+1)*(K+1)+1 cycles.
//   cfg ok: 1<=K<=K_MAX, K<=N<=N_MAX. Else START sets done=1 and cfg_err=1
//     next cycle, no computation, buffers untouched.
//   START while busy ignored. LEN/KLEN writes while busy ignored.
//   y[N-K+1..] keep prior contents. Done/cfg_err sticky until W1C.
//   Reset (rst_i=1) any cycle: FSM->IDLE, regs->0, outputs rvalid=0,
//     gnt follows req, done_int_o=0; buffer contents not cleared.
// TESTING
//   x=[1,2,3,4,5], w=[1,1,1], N=5,K=3, START -> y=[6,9,12], done=1 after 13 cyc.
//   x=[-3,7], w=[2], N=2,K=1, IRQ_EN=1 -> y=[-6,14], done_int_o=1; W1C done -> 0.
//   K=4,N=3 START -> done=1,cfg_err=1,busy never 1, y unchanged.
//   x[0]=0x7FFFFFFF,w[0]=2,N=K=1 -> y[0]=0xFFFFFFFE (wrap).
//   OBI write x[0]=99 while busy -> x[0] unchanged, rvalid returned.
//   rst_i mid-RUN -> busy=0, STATUS=0, new START runs normally.

Source files
------------

// File: rtl/conv1d_accel.sv
// conv1d_accel: memory-mapped 1-D "valid" convolution accelerator.
//   y[i] = sum_{k<K} x[i+k]*w[k], i = 0..N-K, 32-bit wrap-around arithmetic.
// Ports:
//   clk_i, rst_i              clock, synchronous active-high reset
//   obi_*                     OBI subordinate: x at 0x000, w at 0x100, y at 0x200
//   reg_*                     control registers: CTRL, STATUS, LEN, KLEN, IRQ_EN
//   done_int_o                level interrupt, STATUS.done & IRQ_EN
module conv1d_accel #(
  parameter int N_MAX = 64,
  parameter int K_MAX = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        obi_req_i,
  input  logic        obi_we_i,
  input  logic [3:0]  obi_be_i,
  input  logic [31:0] obi_addr_i,
  input  logic [31:0] obi_wdata_i,
  output logic        obi_gnt_o,
  output logic        obi_rvalid_o,
  output logic [31:0] obi_rdata_o,
  output logic        obi_err_o,
  input  logic        reg_valid_i,
  input  logic        reg_write_i,
  input  logic [4:0]  reg_addr_i,
  input  logic [31:0] reg_wdata_i,
  input  logic [3:0]  reg_wstrb_i,
  output logic [31:0] reg_rdata_o,
  output logic        reg_ready_o,
  output logic        reg_error_o,
  output logic        done_int_o
);

  localparam logic [6:0] NMAX7 = 7'(N_MAX);
  localparam logic [3:0] KMAX4 = 4'(K_MAX);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_WRITE, S_DONE} state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_x [N_MAX];
  logic [31:0] r_w [K_MAX];
  logic [31:0] r_y [N_MAX];
  logic [6:0]  r_len;
  logic [3:0]  r_klen;
  logic        r_irq_en, r_done, r_cfg_err;
  logic [5:0]  r_i;
  logic [2:0]  r_k;
  logic [31:0] r_acc;
  logic        r_rvalid;
  logic [31:0] r_rdata;

  logic        w_busy, w_obi_in, w_obi_ker, w_obi_out, w_obi_wr;
  logic [5:0]  w_xidx, w_mac_idx;
  logic [2:0]  w_kidx;
  logic [31:0] w_obi_rd;
  logic        w_reg_wr, w_start, w_cfg_ok, w_k_last, w_i_last;
  logic [2:0]  w_reg_idx;
  logic        w_unused;

  function automatic logic [31:0] f_merge(input logic [31:0] old_v,
                                          input logic [31:0] new_v,
                                          input logic [3:0]  be);
    logic [31:0] res;
    res = old_v;
    for (int unsigned b = 0; b < 4; b++)
      if (be[b]) res[8*b +: 8] = new_v[8*b +: 8];
    return res;
  endfunction

  // ---------------- OBI decode ----------------
  assign w_busy    = (r_state != S_IDLE);
  assign w_obi_in  = (obi_addr_i[9:8] == 2'b00);
  assign w_obi_ker = (obi_addr_i[9:8] == 2'b01) && (obi_addr_i[7:5] == 3'b000);
  assign w_obi_out = (obi_addr_i[9:8] == 2'b10);
  assign w_xidx    = obi_addr_i[7:2];
  assign w_kidx    = obi_addr_i[4:2];
  // Writes are granted while busy but have no effect on the buffers.
  assign w_obi_wr  = obi_req_i & obi_we_i & ~w_busy & ~rst_i;

  always_comb begin
    w_obi_rd = '0;
    if (!obi_we_i) begin
      if (w_obi_in)       w_obi_rd = r_x[w_xidx];
      else if (w_obi_ker) w_obi_rd = r_w[w_kidx];
      else if (w_obi_out) w_obi_rd = r_y[w_xidx];
    end
  end

  assign obi_gnt_o    = obi_req_i;
  assign obi_rvalid_o = r_rvalid;
  assign obi_rdata_o  = r_rdata;
  assign obi_err_o    = 1'b0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_rvalid <= obi_req_i;
      r_rdata  <= obi_req_i ? w_obi_rd : '0;
    end
  end

  // Buffers are deliberately outside reset so their contents survive it.
  always_ff @(posedge clk_i) begin
    if (w_obi_wr && w_obi_in)  r_x[w_xidx] <= f_merge(r_x[w_xidx], obi_wdata_i, obi_be_i);
    if (w_obi_wr && w_obi_ker) r_w[w_kidx] <= f_merge(r_w[w_kidx], obi_wdata_i, obi_be_i);
    if (r_state == S_WRITE)    r_y[r_i] <= r_acc;
  end

  // ---------------- register interface ----------------
  assign w_reg_wr  = reg_valid_i & reg_write_i;
  assign w_reg_idx = reg_addr_i[4:2];
  assign w_start   = w_reg_wr && (w_reg_idx == 3'd0) && reg_wstrb_i[0] && reg_wdata_i[0];
  assign w_cfg_ok  = (r_klen != 4'd0) && (r_klen <= KMAX4) &&
                     ({3'b000, r_klen} <= r_len) && (r_len <= NMAX7);

  always_comb begin
    reg_rdata_o = '0;
    case (w_reg_idx)
      3'd1:    reg_rdata_o = {29'b0, r_cfg_err, r_done, w_busy};
      3'd2:    reg_rdata_o = {25'b0, r_len};
      3'd3:    reg_rdata_o = {28'b0, r_klen};
      3'd4:    reg_rdata_o = {31'b0, r_irq_en};
      default: reg_rdata_o = '0;
    endcase
  end

  assign reg_ready_o = 1'b1;
  assign reg_error_o = reg_valid_i && (w_reg_idx > 3'd4);
  assign done_int_o  = r_done & r_irq_en;

  // ---------------- FSM ----------------
  assign w_mac_idx = r_i + 6'(r_k);
  assign w_k_last  = (r_k == 3'(r_klen - 4'd1));
  assign w_i_last  = ({1'b0, r_i} == (r_len - {3'b000, r_klen}));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_start && w_cfg_ok) w_state_nxt = S_RUN;
      S_RUN:   if (w_k_last) w_state_nxt = S_WRITE;
      S_WRITE: w_state_nxt = w_i_last ? S_DONE : S_RUN;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= S_IDLE;
      r_len     <= '0;
      r_klen    <= '0;
      r_irq_en  <= 1'b0;
      r_done    <= 1'b0;
      r_cfg_err <= 1'b0;
      r_i       <= '0;
      r_k       <= '0;
      r_acc     <= '0;
    end else begin
      r_state <= w_state_nxt;

      if (w_reg_wr && reg_wstrb_i[0]) begin
        if (w_reg_idx == 3'd2 && !w_busy) r_len    <= reg_wdata_i[6:0];
        if (w_reg_idx == 3'd3 && !w_busy) r_klen   <= reg_wdata_i[3:0];
        if (w_reg_idx == 3'd4)            r_irq_en <= reg_wdata_i[0];
        if (w_reg_idx == 3'd1) begin
          if (reg_wdata_i[1]) r_done    <= 1'b0;
          if (reg_wdata_i[2]) r_cfg_err <= 1'b0;
        end
      end

      // Status set events follow the W1C clears so a coincident set wins.
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_i <= '0;
            r_k <= '0;
            if (!w_cfg_ok) begin
              r_done    <= 1'b1;
              r_cfg_err <= 1'b1;
            end
          end
        end
        S_RUN: begin
          r_acc <= ((r_k == 3'd0) ? 32'd0 : r_acc) + r_x[w_mac_idx] * r_w[r_k];
          r_k   <= w_k_last ? 3'd0 : r_k + 3'd1;
        end
        S_WRITE: if (!w_i_last) r_i <= r_i + 6'd1;
        S_DONE:  r_done <= 1'b1;
        default: ;
      endcase
    end
  end

  assign w_unused = ^{obi_addr_i[31:10], obi_addr_i[1:0], reg_addr_i[1:0],
                      reg_wdata_i[31:7], reg_wstrb_i[3:1]};

endmodule

// File: tb/tb_conv1d_accel.sv
// Testbench for conv1d_accel: randomized and directed convolution runs,
// OBI responses checked by a queue-based scoreboard against a reference model.
module tb_conv1d_accel;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        obi_req_i, obi_we_i;
  logic [3:0]  obi_be_i;
  logic [31:0] obi_addr_i, obi_wdata_i;
  logic        obi_gnt_o, obi_rvalid_o, obi_err_o;
  logic [31:0] obi_rdata_o;
  logic        reg_valid_i, reg_write_i;
  logic [4:0]  reg_addr_i;
  logic [31:0] reg_wdata_i;
  logic [3:0]  reg_wstrb_i;
  logic [31:0] reg_rdata_o;
  logic        reg_ready_o, reg_error_o, done_int_o;

  conv1d_accel #(.N_MAX(64), .K_MAX(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .obi_req_i(obi_req_i), .obi_we_i(obi_we_i), .obi_be_i(obi_be_i),
    .obi_addr_i(obi_addr_i), .obi_wdata_i(obi_wdata_i),
    .obi_gnt_o(obi_gnt_o), .obi_rvalid_o(obi_rvalid_o),
    .obi_rdata_o(obi_rdata_o), .obi_err_o(obi_err_o),
    .reg_valid_i(reg_valid_i), .reg_write_i(reg_write_i),
    .reg_addr_i(reg_addr_i), .reg_wdata_i(reg_wdata_i),
    .reg_wstrb_i(reg_wstrb_i), .reg_rdata_o(reg_rdata_o),
    .reg_ready_o(reg_ready_o), .reg_error_o(reg_error_o),
    .done_int_o(done_int_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;
  int issued = 0;
  int resp   = 0;
  logic [31:0] exp_q[$];

  // Reference model state
  logic [31:0] xm [64];
  logic [31:0] wm [8];
  logic [31:0] ym [64];
  bit          irq_m = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: one response per granted OBI request.
  always @(negedge clk_i) begin : monitor
    logic [31:0] e;
    if (obi_rvalid_o) begin
      resp++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL obi_unexpected_rvalid: got rdata 0x%08h expected no response", obi_rdata_o);
      end else begin
        e = exp_q.pop_front();
        check("obi_rdata", obi_rdata_o, e);
        check("obi_err", {31'b0, obi_err_o}, 32'd0);
      end
    end
  end

  // All stimulus tasks start and end at posedge+1.
  task automatic obi_xfer(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, input logic [31:0] exp);
    obi_req_i = 1'b1; obi_we_i = we; obi_addr_i = addr; obi_wdata_i = wdata; obi_be_i = be;
    exp_q.push_back(we ? 32'd0 : exp);
    issued++;
    #1 check("obi_gnt", {31'b0, obi_gnt_o}, 32'd1);
    @(posedge clk_i); #1;
    obi_req_i = 1'b0; obi_we_i = 1'b0;
  endtask

  task automatic wx(input int i, input logic [31:0] v);
    obi_xfer(1'b1, 32'(4 * i), v, 4'hF, 32'd0);
    xm[i] = v;
  endtask

  task automatic ww(input int i, input logic [31:0] v);
    obi_xfer(1'b1, 32'(256 + 4 * i), v, 4'hF, 32'd0);
    wm[i] = v;
  endtask

  task automatic ry_all();
    for (int i = 0; i < 64; i++) obi_xfer(1'b0, 32'(512 + 4 * i), 32'd0, 4'h0, ym[i]);
  endtask

  task automatic reg_wr(input logic [4:0] a, input logic [31:0] d);
    reg_valid_i = 1'b1; reg_write_i = 1'b1; reg_addr_i = a; reg_wdata_i = d; reg_wstrb_i = 4'hF;
    #1 check("reg_ready", {31'b0, reg_ready_o}, 32'd1);
    @(posedge clk_i); #1;
    reg_valid_i = 1'b0; reg_write_i = 1'b0;
  endtask

  task automatic reg_rd(input logic [4:0] a, input logic [31:0] e, input string name);
    reg_valid_i = 1'b1; reg_write_i = 1'b0; reg_addr_i = a;
    #1 check(name, reg_rdata_o, e);
    reg_valid_i = 1'b0;
  endtask

  // Reference: plain sum-of-products with 32-bit wrap.
  task automatic model_conv(input int n, input int k);
    logic [31:0] acc;
    for (int i = 0; i <= n - k; i++) begin
      acc = 32'd0;
      for (int j = 0; j < k; j++) acc = acc + xm[i + j] * wm[j];
      ym[i] = acc;
    end
  endtask

  task automatic run(input int n, input int k, input bit poke);
    int cyc;
    int exp_cyc;
    reg_wr(5'h08, 32'(n));
    reg_wr(5'h0C, 32'(k));
    reg_wr(5'h00, 32'd1);
    reg_rd(5'h04, 32'h1, "busy_after_start");
    cyc = 0;
    if (poke) begin
      obi_xfer(1'b1, 32'h0, 32'd99, 4'hF, 32'd0);
      reg_wr(5'h08, 32'd7);
      reg_wr(5'h0C, 32'd2);
      reg_wr(5'h00, 32'd1);
      cyc = 4;
    end
    exp_cyc = (n - k + 1) * (k + 1) + 1;
    reg_addr_i = 5'h04;
    #1;
    while (!reg_rdata_o[1] && cyc < 5000) begin
      @(posedge clk_i); #1;
      cyc++;
    end
    check("done_latency", 32'(cyc), 32'(exp_cyc));
    reg_rd(5'h04, 32'h2, "status_done");
    check("done_int", {31'b0, done_int_o}, {31'b0, irq_m});
    model_conv(n, k);
    if (poke) begin
      reg_rd(5'h08, 32'(n), "len_locked_busy");
      reg_rd(5'h0C, 32'(k), "klen_locked_busy");
    end
    reg_wr(5'h04, 32'h6);
    reg_rd(5'h04, 32'h0, "status_w1c");
    check("done_int_cleared", {31'b0, done_int_o}, 32'd0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1);
  end

  initial begin : stim
    int n, k;
    logic [31:0] v;
    int bad_n[5] = '{3, 20, 20, 65, 127};
    int bad_k[5] = '{4, 0, 9, 1, 8};

    rst_i = 1'b1;
    obi_req_i = 0; obi_we_i = 0; obi_be_i = 0; obi_addr_i = 0; obi_wdata_i = 0;
    reg_valid_i = 0; reg_write_i = 0; reg_addr_i = 0; reg_wdata_i = 0; reg_wstrb_i = 0;
    repeat (2) @(posedge clk_i);
    #1;
    // Request during reset: granted, but no response.
    obi_req_i = 1'b1; obi_addr_i = 32'h0;
    #1 check("gnt_in_reset", {31'b0, obi_gnt_o}, 32'd1);
    @(posedge clk_i); #1;
    obi_req_i = 1'b0;
    check("rvalid_in_reset", {31'b0, obi_rvalid_o}, 32'd0);
    check("done_int_reset", {31'b0, done_int_o}, 32'd0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;

    reg_rd(5'h00, 32'h0, "ctrl_reset");
    reg_rd(5'h04, 32'h0, "status_reset");
    reg_rd(5'h08, 32'h0, "len_reset");
    reg_rd(5'h0C, 32'h0, "klen_reset");
    reg_rd(5'h10, 32'h0, "irqen_reset");
    reg_valid_i = 1'b1; reg_addr_i = 5'h14;
    #1 check("reg_error_unmapped", {31'b0, reg_error_o}, 32'd1);
    reg_addr_i = 5'h10;
    #1 check("reg_error_mapped", {31'b0, reg_error_o}, 32'd0);
    reg_valid_i = 1'b0;

    // Fill every buffer so the model is fully known.
    for (int i = 0; i < 64; i++) wx(i, $urandom);
    for (int i = 0; i < 8; i++)  ww(i, $urandom);
    run(64, 1, 1'b0);
    ry_all();

    // Directed moving sum
    for (int i = 0; i < 5; i++) wx(i, 32'(i + 1));
    for (int i = 0; i < 3; i++) ww(i, 32'd1);
    run(5, 3, 1'b0);
    obi_xfer(1'b0, 32'h200, 32'd0, 4'h0, 32'd6);
    obi_xfer(1'b0, 32'h204, 32'd0, 4'h0, 32'd9);
    obi_xfer(1'b0, 32'h208, 32'd0, 4'h0, 32'd12);
    ry_all();

    // Signed data with interrupt enabled
    reg_wr(5'h10, 32'd1);
    irq_m = 1'b1;
    reg_rd(5'h10, 32'h1, "irqen_set");
    wx(0, 32'hFFFF_FFFD); wx(1, 32'd7); ww(0, 32'd2);
    run(2, 1, 1'b0);
    obi_xfer(1'b0, 32'h200, 32'd0, 4'h0, 32'hFFFF_FFFA);
    obi_xfer(1'b0, 32'h204, 32'd0, 4'h0, 32'd14);
    reg_wr(5'h10, 32'd0);
    irq_m = 1'b0;

    // Product wrap-around
    wx(0, 32'h7FFF_FFFF); ww(0, 32'd2);
    run(1, 1, 1'b0);
    obi_xfer(1'b0, 32'h200, 32'd0, 4'h0, 32'hFFFF_FFFE);

    // Bad configurations: immediate done+cfg_err, never busy
    for (int t = 0; t < 5; t++) begin
      reg_wr(5'h08, 32'(bad_n[t]));
      reg_wr(5'h0C, 32'(bad_k[t]));
      reg_wr(5'h00, 32'd1);
      for (int c = 0; c < 3; c++) begin
        reg_rd(5'h04, 32'h6, "cfgerr_status");
        @(posedge clk_i); #1;
      end
      reg_wr(5'h04, 32'h2);
      reg_rd(5'h04, 32'h4, "cfgerr_sticky");
      reg_wr(5'h04, 32'h4);
      reg_rd(5'h04, 32'h0, "cfgerr_w1c");
    end
    ry_all();

    // Writes while busy dropped; output buffer read-only; unmapped reads 0
    run(16, 4, 1'b1);
    obi_xfer(1'b0, 32'h0, 32'd0, 4'h0, xm[0]);
    obi_xfer(1'b1, 32'h200, 32'hDEAD_BEEF, 4'hF, 32'd0);
    obi_xfer(1'b0, 32'h200, 32'd0, 4'h0, ym[0]);
    obi_xfer(1'b0, 32'h300, 32'd0, 4'h0, 32'd0);
    obi_xfer(1'b0, 32'h120, 32'd0, 4'h0, 32'd0);
    obi_xfer(1'b0, 32'h11C, 32'd0, 4'h0, wm[7]);

    // Partial byte-enable write
    v = $urandom;
    obi_xfer(1'b1, 32'h4, v, 4'b0101, 32'd0);
    xm[1] = (xm[1] & 32'hFF00_FF00) | (v & 32'h00FF_00FF);
    obi_xfer(1'b0, 32'h4, 32'd0, 4'h0, xm[1]);

    // Reset in the middle of a run, then a clean rerun
    reg_wr(5'h08, 32'd20);
    reg_wr(5'h0C, 32'd3);
    reg_wr(5'h00, 32'd1);
    repeat (10) @(posedge clk_i);
    #1 rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    reg_rd(5'h04, 32'h0, "status_after_rst");
    reg_rd(5'h08, 32'h0, "len_after_rst");
    run(20, 3, 1'b0);
    ry_all();

    // Randomized configurations
    for (int t = 0; t < 6; t++) begin
      k = int'($urandom_range(1, 8));
      n = int'($urandom_range(k, 64));
      for (int i = 0; i < n; i++) wx(i, $urandom);
      for (int i = 0; i < k; i++) ww(i, $urandom);
      run(n, k, 1'b0);
      ry_all();
    end

    repeat (5) @(posedge clk_i);
    #1;
    check("obi_responses", 32'(resp), 32'(issued));
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
